// File: rtl/regfile_snapshot.sv
// Register-memory snapshot sequencer: dumps all registers to a stream or reloads them from one.
// Optional SNAPSHOT_CHECKSUM_EN appends/verifies an XOR checksum word.
module regfile_snapshot #(
    parameter int ADDR_SIZE = 4,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dump_start,
    input  logic                 load_start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_SIZE-1:0] raddr,
    input  logic [BYTE_SIZE-1:0] rdata,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [BYTE_SIZE-1:0] wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BYTE_SIZE-1:0] out_data,
    output logic                 out_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BYTE_SIZE-1:0] in_data
);
    localparam int IW = ADDR_SIZE + 1;
    localparam logic [IW-1:0] LAST_REG = IW'((1 << ADDR_SIZE) - 1);
`ifdef SNAPSHOT_CHECKSUM_EN
    localparam logic [IW-1:0] LAST_DUMP = IW'(1 << ADDR_SIZE);
`else
    localparam logic [IW-1:0] LAST_DUMP = LAST_REG;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMP,
        S_LOAD
`ifdef SNAPSHOT_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          dumping;
    logic          loading;
    logic          dump_hs;
    logic          load_hs;

    assign dumping = (state == S_DUMP);
    assign loading = (state == S_LOAD);

    assign out_valid = dumping;
    assign out_last  = dumping && (idx == LAST_DUMP);
    assign raddr     = dumping ? idx[ADDR_SIZE-1:0] : '0;
    assign wen       = loading & in_valid;
    assign waddr     = loading ? idx[ADDR_SIZE-1:0] : '0;
    assign wdata     = loading ? in_data : '0;
    assign dump_hs   = out_valid & out_ready;
    assign load_hs   = in_valid & in_ready;

`ifdef SNAPSHOT_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] csum;
    logic                 err_q;

    assign in_ready = loading || (state == S_CHECK);
    // The word after register N-1 is the checksum, not memory data.
    assign out_data = !dumping ? '0 : (idx == LAST_DUMP) ? csum : rdata;
    assign err      = err_q;
`else
    assign in_ready = loading;
    assign out_data = dumping ? rdata : '0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
            csum  <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
`ifdef SNAPSHOT_CHECKSUM_EN
                    csum <= '0;
`endif
                    if (dump_start) begin
                        state <= S_DUMP;
                        busy  <= 1'b1;
                    end else if (load_start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
`ifdef SNAPSHOT_CHECKSUM_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                S_DUMP: begin
                    if (dump_hs) begin
`ifdef SNAPSHOT_CHECKSUM_EN
                        csum <= csum ^ rdata;
`endif
                        if (idx == LAST_DUMP) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
`ifdef SNAPSHOT_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (idx == LAST_REG) begin
                            idx <= '0;
`ifdef SNAPSHOT_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
`ifdef SNAPSHOT_CHECKSUM_EN
                S_CHECK: begin
                    if (load_hs) begin
                        if (in_data != csum)
                            err_q <= 1'b1;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
